// File: rtl/branch_seq_ctrl_pkg.sv
// rtl/branch_seq_ctrl_pkg.sv - shared op encodings, FSM states and constants for branch_seq_ctrl
package branch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_BEQZ = 2'b00,
    OP_BNEZ = 2'b01,
    OP_JMP  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EVAL  = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  localparam int unsigned PC_INC = 4;

  // Branch direction from the opcode and the zero-detect result.
  function automatic logic resolve_taken(input op_e op, input logic eqz, input logic neqz);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQZ: t = eqz;
      OP_BNEZ: t = neqz;
      OP_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_seq_ctrl_zero_cmp.sv
// rtl/branch_seq_ctrl_zero_cmp.sv - combinational W-bit zero detector (module zero_cmp)
module zero_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] operand,
  output logic         eqz,
  output logic         neqz
);

  assign neqz = |operand;
  assign eqz  = ~neqz;

endmodule

// File: rtl/branch_seq_ctrl.sv
// rtl/branch_seq_ctrl.sv - multicycle branch resolver driving the fetch redirect PC
// Optional BRANCH_STATS_EN adds saturating handshake counters stat_total / stat_taken.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_z,
  input  logic [AW-1:0] req_pc,
  input  logic [AW-1:0] req_off,
  output logic          pc_valid,
  input  logic          pc_ready,
  output logic [AW-1:0] pc_next,
  output logic          taken,
  output logic          flush,
  output logic          busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]   stat_total,
  output logic [15:0]   stat_taken
`endif
);

  state_e        state, state_nxt;
  op_e           op_r;
  logic [DW-1:0] z_r;
  logic [AW-1:0] pc_r;
  logic [AW-1:0] off_r;
  logic [AW-1:0] pc_next_r;
  logic          taken_r;

  logic          capture;
  logic          resolve;
  logic          handshake;
  logic          eqz;
  logic          neqz;
  logic          taken_eval;
  logic [AW-1:0] pc_eval;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    pc_valid  = 1'b0;
    busy      = 1'b1;
    capture   = 1'b0;
    resolve   = 1'b0;
    handshake = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          capture   = 1'b1;
          state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        resolve   = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        pc_valid = 1'b1;
        if (pc_ready) begin
          handshake = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  zero_cmp #(.W(DW)) u_zero_cmp (
    .operand (z_r),
    .eqz     (eqz),
    .neqz    (neqz)
  );

  assign taken_eval = resolve_taken(op_r, eqz, neqz);
  // Single adder: the second operand picks target offset or fall-through step.
  assign pc_eval    = pc_r + (taken_eval ? off_r : AW'(PC_INC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= OP_BEQZ;
      z_r       <= '0;
      pc_r      <= '0;
      off_r     <= '0;
      pc_next_r <= '0;
      taken_r   <= 1'b0;
    end else begin
      if (capture) begin
        op_r  <= op_e'(req_op);
        z_r   <= req_z;
        pc_r  <= req_pc;
        off_r <= req_off;
      end
      if (resolve) begin
        pc_next_r <= pc_eval;
        taken_r   <= taken_eval;
      end
    end
  end

  assign pc_next = pc_next_r;
  assign taken   = taken_r;
  assign flush   = handshake & taken_r;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_total_r;
  logic [15:0] stat_taken_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total_r <= '0;
      stat_taken_r <= '0;
    end else if (handshake) begin
      if (stat_total_r != 16'hFFFF) stat_total_r <= stat_total_r + 16'd1;
      if (taken_r && stat_taken_r != 16'hFFFF) stat_taken_r <= stat_taken_r + 16'd1;
    end
  end

  assign stat_total = stat_total_r;
  assign stat_taken = stat_taken_r;
`endif

endmodule
